// File: rtl/elastic_pipeline.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, bubble collapsing and flush.
// Define ELASTIC_PIPELINE_SKID_EN to add a one-entry input skid that registers in_ready.
module elastic_pipeline #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // r[i]: stage i may load this cycle (it is empty or everything downstream moves).
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  logic             in_xfer;
  logic             out_xfer;
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;

  always_comb begin
    logic hole;
    hole     = 1'b0;
    r        = '0;
    r[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      hole = hole | ~v_q[i];
      r[i] = out_ready | hole;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_xfer  = out_valid & out_ready;
  assign count     = count_q;

`ifdef ELASTIC_PIPELINE_SKID_EN
  logic             sv_q, sv_d;
  logic [WIDTH-1:0] sd_q, sd_d;

  // in_ready depends only on registered state, cutting the out_ready->in_ready path.
  assign in_ready = ~sv_q & ~flush;
  assign in_xfer  = in_valid & in_ready;
  assign s0_valid = sv_q | in_xfer;
  assign s0_data  = sv_q ? sd_q : in_data;

  always_comb begin
    sv_d = sv_q;
    sd_d = sd_q;
    if (flush) begin
      sv_d = 1'b0;
    end else if (sv_q && r[0]) begin
      sv_d = 1'b0;
    end else if (in_xfer && !r[0]) begin
      sv_d = 1'b1;
      sd_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sv_q <= 1'b0;
      sd_q <= '0;
    end else begin
      sv_q <= sv_d;
      sd_q <= sd_d;
    end
  end
`else
  assign in_ready = r[0] & ~flush;
  assign in_xfer  = in_valid & in_ready;
  assign s0_valid = in_xfer;
  assign s0_data  = in_data;
`endif

  always_comb begin
    up_v    = (v_q << 1) | DEPTH'(s0_valid);
    up_d[0] = s0_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r[i]) begin
        v_d[i] = up_v[i];
        if (up_v[i] && !flush) begin
          d_d[i] = up_d[i];
        end
      end
    end
    if (flush) begin
      v_d = '0;
    end
  end

  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Scoreboard bench for elastic_pipeline (WIDTH=16, DEPTH=8): stimulus pushes accepted words,
// an independent monitor pops and compares on every output transfer.
module tb_elastic_pipeline;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 2);
`ifdef ELASTIC_PIPELINE_SKID_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int checks;
  int failures;
  logic [WIDTH-1:0] exp_q[$];
  int rst_epoch;

  elastic_pipeline #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on output transfer plus output stability under stall.
  logic             stall_q;
  logic [WIDTH-1:0] stall_data;
  int               epoch_seen;
  logic [WIDTH-1:0] exp_w;

  initial begin
    stall_q    = 1'b0;
    stall_data = '0;
    epoch_seen = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (stall_q && epoch_seen == rst_epoch) begin
        chk("stable_out_valid", 32'(out_valid), 32'd1);
        chk("stable_out_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output got=%0h expected=none at %0t", out_data, $time);
        end else begin
          exp_w = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(exp_w));
        end
      end
      stall_q    = out_valid && !out_ready && !flush;
      stall_data = out_data;
      epoch_seen = rst_epoch;
    end else begin
      stall_q = 1'b0;
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                     input logic fl, output logic acc);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(id);
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int k = 0; k < n; k++) cyc(1'b0, '0, ordy, 1'b0, acc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n_acc;
    checks    = 0;
    failures  = 0;
    rst_epoch = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #10;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #5 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Streaming: first output visible 7 edges after first accept, count steady at DEPTH.
    for (int c = 0; c < 20; c++) begin
      if (c == 7) chk("stream_latency_lo", 32'(out_valid), 32'd0);
      if (c == 8) chk("stream_latency_hi", 32'(out_valid), 32'd1);
      if (c == 12) chk("stream_count", 32'(count), 32'(DEPTH));
      cyc(1'b1, WIDTH'(c + 1), 1'b1, 1'b0, acc);
    end
    idle(12, 1'b1);
    chk("stream_drained_count", 32'(count), 32'd0);
    chk("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure fill: exactly CAP of 12 attempts accepted.
    n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(1'b1, WIDTH'(c + 1), 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("fill_accepted", 32'(n_acc), 32'(CAP));
    chk("fill_count", 32'(count), 32'(CAP));
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    idle(12, 1'b1);
    chk("fill_drained_count", 32'(count), 32'd0);
    chk("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // Bubble collapse: three sparse words settle at the output end, then leave back to back.
    cyc(1'b1, 16'h000A, 1'b0, 1'b0, acc);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0, acc);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, acc);
    cyc(1'b1, 16'h000C, 1'b0, 1'b0, acc);
    idle(10, 1'b0);
    chk("bubble_count", 32'(count), 32'd3);
    chk("bubble_head", 32'(out_data), 32'h000A);
    for (int c = 0; c < 4; c++) begin
      chk("bubble_consecutive", 32'(out_valid), (c < 3) ? 32'd1 : 32'd0);
      cyc(1'b0, '0, 1'b1, 1'b0, acc);
    end
    chk("bubble_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full pipeline with simultaneous in and out.
    for (int c = 0; c < int'(DEPTH); c++) cyc(1'b1, WIDTH'(16'h0100 + c), 1'b0, 1'b0, acc);
    chk("full_count", 32'(count), 32'(DEPTH));
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, WIDTH'(16'h0110 + c), 1'b1, 1'b0, acc);
      chk("full_passthru_ready", 32'(acc), 32'd1);
      chk("full_passthru_count", 32'(count), 32'(DEPTH));
    end
    idle(12, 1'b1);
    chk("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with 5 words held; input offered during flush must be refused.
    for (int c = 0; c < 5; c++) cyc(1'b1, WIDTH'(16'h0200 + c), 1'b0, 1'b0, acc);
    chk("flush_pre_count", 32'(count), 32'd5);
    cyc(1'b1, 16'h0055, 1'b0, 1'b1, acc);
    chk("flush_in_refused", 32'(acc), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 16'h0077, 1'b1, 1'b0, acc);
    idle(12, 1'b1);
    chk("flush_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges.
    for (int c = 0; c < 6; c++) cyc(1'b1, WIDTH'(16'h0300 + c), 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    chk("areset_pre_count", 32'(count), 32'd6);
    #2;
    reset = 1'b0;
    rst_epoch++;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    chk("areset_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 16'h0099, 1'b1, 1'b0, acc);
    idle(12, 1'b1);
    chk("areset_recover_empty", 32'(exp_q.size()), 32'd0);
    chk("areset_recover_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
